// File: rtl/obj_pool_if.sv
// obj_pool_if: bundles the request/grant, allocation response, free port and pool status
// signals of obj_pool_arbiter.
//   master : requester/owner side (drives req_valid, req_single, free_valid, free_id)
//   slave  : allocator side (drives req_ready, alloc_*, pool_*, err_double_free)
// Optional feature macro: OBJ_POOL_SINGLETON_EN adds req_single.
interface obj_pool_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned N_OBJ = 16
);
    localparam int unsigned ID_W  = $clog2(N_OBJ);
    localparam int unsigned CNT_W = $clog2(N_OBJ + 1);
    localparam int unsigned OWN_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
`ifdef OBJ_POOL_SINGLETON_EN
    logic [N_REQ-1:0] req_single;
`endif
    logic             alloc_valid;
    logic [ID_W-1:0]  alloc_id;
    logic [OWN_W-1:0] alloc_owner;
    logic             free_valid;
    logic [ID_W-1:0]  free_id;
    logic [CNT_W-1:0] pool_count;
    logic             pool_empty;
    logic             err_double_free;

`ifdef OBJ_POOL_SINGLETON_EN
    modport master (
        output req_valid, req_single, free_valid, free_id,
        input  req_ready, alloc_valid, alloc_id, alloc_owner, pool_count, pool_empty,
               err_double_free
    );
    modport slave (
        input  req_valid, req_single, free_valid, free_id,
        output req_ready, alloc_valid, alloc_id, alloc_owner, pool_count, pool_empty,
               err_double_free
    );
`else
    modport master (
        output req_valid, free_valid, free_id,
        input  req_ready, alloc_valid, alloc_id, alloc_owner, pool_count, pool_empty,
               err_double_free
    );
    modport slave (
        input  req_valid, free_valid, free_id,
        output req_ready, alloc_valid, alloc_id, alloc_owner, pool_count, pool_empty,
               err_double_free
    );
`endif
endinterface

// File: rtl/obj_pool_arbiter.sv
// obj_pool_arbiter: allocates unique handles from a pool of N_OBJ to N_REQ requesters.
// Round-robin arbitration, one grant per cycle, lowest free handle first; handles come back
// through a single free port with double-free detection.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : obj_pool_if.slave (req_valid/req_ready grant handshake, alloc_valid/id/owner
//          response one cycle after grant, free_valid/free_id return, pool_count,
//          pool_empty, err_double_free)
// Optional feature macro: OBJ_POOL_SINGLETON_EN reserves handle N_OBJ-1 as a shared
// singleton, requested with req_valid[k] & req_single[k].
module obj_pool_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned N_OBJ = 16
) (
    input logic       clk,
    input logic       rst,
    obj_pool_if.slave bus
);
    localparam int unsigned ID_W  = $clog2(N_OBJ);
    localparam int unsigned CNT_W = $clog2(N_OBJ + 1);
    localparam int unsigned OWN_W = $clog2(N_REQ);

    localparam logic [ID_W-1:0] SINGLE_ID = ID_W'(N_OBJ - 1);
`ifdef OBJ_POOL_SINGLETON_EN
    localparam logic [N_OBJ-1:0] MAP_RST = {1'b0, {(N_OBJ - 1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(N_OBJ - 1);
`else
    localparam logic [N_OBJ-1:0] MAP_RST = '1;
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(N_OBJ);
`endif

    logic [N_OBJ-1:0] free_map_q, free_map_d;
    logic [CNT_W-1:0] pool_count_q, pool_count_d;
    logic [OWN_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             alloc_valid_q, alloc_valid_d;
    logic [ID_W-1:0]  alloc_id_q, alloc_id_d;
    logic [OWN_W-1:0] alloc_owner_q, alloc_owner_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] req_single;
    logic [N_REQ-1:0] eligible;
    logic             pool_avail;
    logic [ID_W-1:0]  low_id;
    logic             grant_any;
    logic [OWN_W-1:0] grant_idx;
    logic             grant_single;
    logic             take_pool;
    logic             free_ignored;
    logic             free_ok;

`ifdef OBJ_POOL_SINGLETON_EN
    assign req_single   = bus.req_single;
    assign free_ignored = (bus.free_id == SINGLE_ID);
`else
    assign req_single   = '0;
    assign free_ignored = 1'b0;
`endif

    assign pool_avail = (pool_count_q != '0);
    // Singleton requests need no pool handle, so they stay eligible on an empty pool.
    assign eligible   = bus.req_valid & ({N_REQ{pool_avail}} | req_single);

    // Lowest-index free handle; scanning downwards leaves the lowest hit last.
    always_comb begin
        low_id = '0;
        for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
            if (free_map_q[ID_W'(i)]) low_id = ID_W'(i);
        end
    end

    // Round-robin search starting at rr_ptr_q, wrapping modulo N_REQ.
    always_comb begin
        int unsigned      idx;
        logic [OWN_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = OWN_W'(idx);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (rst) grant_any = 1'b0;
    end

    assign grant_single  = grant_any && req_single[grant_idx];
    assign take_pool     = grant_any && !grant_single;
    assign bus.req_ready = grant_any ? (N_REQ'(1) << grant_idx) : '0;

    always_comb begin
        free_map_d    = free_map_q;
        rr_ptr_d      = rr_ptr_q;
        alloc_valid_d = grant_any;
        alloc_id_d    = alloc_id_q;
        alloc_owner_d = alloc_owner_q;
        err_d         = 1'b0;
        free_ok       = 1'b0;

        if (grant_any) begin
            rr_ptr_d      = (grant_idx == OWN_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            alloc_owner_d = grant_idx;
            alloc_id_d    = grant_single ? SINGLE_ID : low_id;
        end
        if (take_pool) free_map_d[low_id] = 1'b0;

        // Double-free is judged against the map before this cycle's grant, so a handle
        // freed now is never a grant candidate in the same cycle.
        if (bus.free_valid && !free_ignored) begin
            if (free_map_q[bus.free_id]) begin
                err_d = 1'b1;
            end else begin
                free_map_d[bus.free_id] = 1'b1;
                free_ok                 = 1'b1;
            end
        end

        pool_count_d = pool_count_q - CNT_W'(take_pool) + CNT_W'(free_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_map_q    <= MAP_RST;
            pool_count_q  <= CNT_RST;
            rr_ptr_q      <= '0;
            alloc_valid_q <= 1'b0;
            alloc_id_q    <= '0;
            alloc_owner_q <= '0;
            err_q         <= 1'b0;
        end else begin
            free_map_q    <= free_map_d;
            pool_count_q  <= pool_count_d;
            rr_ptr_q      <= rr_ptr_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_id_q    <= alloc_id_d;
            alloc_owner_q <= alloc_owner_d;
            err_q         <= err_d;
        end
    end

    assign bus.alloc_valid     = alloc_valid_q;
    assign bus.alloc_id        = alloc_id_q;
    assign bus.alloc_owner     = alloc_owner_q;
    assign bus.pool_count      = pool_count_q;
    assign bus.pool_empty      = (pool_count_q == '0);
    assign bus.err_double_free = err_q;
endmodule

// File: tb/tb_obj_pool_arbiter.sv
// tb_obj_pool_arbiter: directed scenarios plus randomized traffic against a
// behavioural pool model (array of free flags, round-robin pointer, counts).
module tb_obj_pool_arbiter;
    localparam int N_REQ = 4;
    localparam int N_OBJ = 16;
    localparam int ID_W  = 4;
    localparam int CNT_W = 5;
`ifdef OBJ_POOL_SINGLETON_EN
    localparam int RES = 1;
`else
    localparam int RES = 0;
`endif

    logic clk;
    logic rst;

    obj_pool_if #(.N_REQ(N_REQ), .N_OBJ(N_OBJ)) bus ();

    obj_pool_arbiter #(.N_REQ(N_REQ), .N_OBJ(N_OBJ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    bit m_free[N_OBJ];
    int m_count;
    int m_rr;
    int exp_av, exp_id, exp_owner, exp_err;

    int n_cmp;
    int n_bad;

    task automatic model_reset();
        for (int i = 0; i < N_OBJ; i++) m_free[i] = !(RES == 1 && i == N_OBJ - 1);
        m_count   = N_OBJ - RES;
        m_rr      = 0;
        exp_av    = 0;
        exp_id    = 0;
        exp_owner = 0;
        exp_err   = 0;
    endtask

    // One clock: drive inputs, check the combinational grant, step the model, check outputs.
    task automatic do_cycle(input string name, input logic [N_REQ-1:0] rv,
                            input logic [N_REQ-1:0] rs, input logic fv, input int fid,
                            input logic r);
        int               g;
        int               low;
        bit               was_free;
        bit               ign;
        logic [N_REQ-1:0] exp_rdy;
        bus.req_valid  = rv;
        bus.free_valid = fv;
        bus.free_id    = fid[ID_W-1:0];
`ifdef OBJ_POOL_SINGLETON_EN
        bus.req_single = rs;
`endif
        rst = r;
        #1;
        g = -1;
        if (!r) begin
            for (int i = 0; i < N_REQ; i++) begin
                int k;
                k = (m_rr + i) % N_REQ;
                if (g < 0 && rv[k] && (m_count > 0 || (RES == 1 && rs[k]))) g = k;
            end
        end
        exp_rdy = (g < 0) ? '0 : (N_REQ'(1) << g);
        n_cmp++;
        if (bus.req_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL %s req_ready: got %b want %b", name, bus.req_ready, exp_rdy);
        end
        low = -1;
        for (int i = 0; i < N_OBJ; i++) if (low < 0 && m_free[i]) low = i;
        ign      = fv && (RES == 1 && fid == N_OBJ - 1);
        was_free = fv && !ign && m_free[fid];

        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            exp_av  = 0;
            exp_err = 0;
            if (g >= 0) begin
                exp_av    = 1;
                exp_owner = g;
                m_rr      = (g + 1) % N_REQ;
                if (RES == 1 && rs[g]) exp_id = N_OBJ - 1;
                else begin
                    exp_id        = low;
                    m_free[low]   = 0;
                    m_count--;
                end
            end
            if (fv && !ign) begin
                if (was_free) exp_err = 1;
                else begin
                    m_free[fid] = 1;
                    m_count++;
                end
            end
        end

        n_cmp++;
        if (bus.alloc_valid !== exp_av[0]) begin
            n_bad++;
            $display("FAIL %s alloc_valid: got %b want %0d", name, bus.alloc_valid, exp_av);
        end
        if (exp_av != 0) begin
            n_cmp++;
            if (bus.alloc_id !== ID_W'(exp_id)) begin
                n_bad++;
                $display("FAIL %s alloc_id: got %0d want %0d", name, bus.alloc_id, exp_id);
            end
            n_cmp++;
            if (bus.alloc_owner !== 2'(exp_owner)) begin
                n_bad++;
                $display("FAIL %s alloc_owner: got %0d want %0d", name, bus.alloc_owner,
                         exp_owner);
            end
        end
        n_cmp++;
        if (bus.err_double_free !== exp_err[0]) begin
            n_bad++;
            $display("FAIL %s err_double_free: got %b want %0d", name, bus.err_double_free,
                     exp_err);
        end
        n_cmp++;
        if (bus.pool_count !== CNT_W'(m_count)) begin
            n_bad++;
            $display("FAIL %s pool_count: got %0d want %0d", name, bus.pool_count, m_count);
        end
        n_cmp++;
        if (bus.pool_empty !== (m_count == 0)) begin
            n_bad++;
            $display("FAIL %s pool_empty: got %b want %0d", name, bus.pool_empty,
                     (m_count == 0));
        end
    endtask

    task automatic test_reset();
        do_cycle("reset", 4'b1111, 4'b0000, 1'b1, 3, 1'b1);
        n_cmp++;
        if (bus.alloc_id !== '0 || bus.alloc_owner !== '0) begin
            n_bad++;
            $display("FAIL reset_id_owner: got %0d/%0d want 0/0", bus.alloc_id,
                     bus.alloc_owner);
        end
        n_cmp++;
        if (bus.pool_count !== CNT_W'(N_OBJ - RES)) begin
            n_bad++;
            $display("FAIL reset_count: got %0d want %0d", bus.pool_count, N_OBJ - RES);
        end
        do_cycle("reset_idle", 4'b0000, 4'b0000, 1'b0, 0, 1'b0);
    endtask

    task automatic test_single_requester();
        do_cycle("one_req_rst", 4'b0000, 4'b0000, 1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            do_cycle("one_req", 4'b0001, 4'b0000, 1'b0, 0, 1'b0);
            n_cmp++;
            if (bus.alloc_id !== ID_W'(i) || bus.alloc_owner !== 2'd0) begin
                n_bad++;
                $display("FAIL one_req_seq: got id %0d owner %0d want id %0d owner 0",
                         bus.alloc_id, bus.alloc_owner, i);
            end
        end
        n_cmp++;
        if (bus.pool_count !== CNT_W'(N_OBJ - RES - 3)) begin
            n_bad++;
            $display("FAIL one_req_count: got %0d want %0d", bus.pool_count, N_OBJ - RES - 3);
        end
        do_cycle("one_req_idle", 4'b0000, 4'b0000, 1'b0, 0, 1'b0);
    endtask

    task automatic test_round_robin();
        do_cycle("rr_rst", 4'b0000, 4'b0000, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            do_cycle("rr", 4'b1111, 4'b0000, 1'b0, 0, 1'b0);
            n_cmp++;
            if (bus.alloc_owner !== 2'(i) || bus.alloc_id !== ID_W'(i)) begin
                n_bad++;
                $display("FAIL rr_order: got owner %0d id %0d want %0d", bus.alloc_owner,
                         bus.alloc_id, i);
            end
        end
        // Pointer has wrapped: requester 0 wins again.
        do_cycle("rr_wrap", 4'b1111, 4'b0000, 1'b0, 0, 1'b0);
        do_cycle("rr_idle", 4'b0000, 4'b0000, 1'b0, 0, 1'b0);
    endtask

    task automatic test_empty_pool();
        do_cycle("empty_rst", 4'b0000, 4'b0000, 1'b0, 0, 1'b1);
        for (int i = 0; i < N_OBJ - RES; i++)
            do_cycle("empty_fill", 4'b0001, 4'b0000, 1'b0, 0, 1'b0);
        do_cycle("empty_wait", 4'b0100, 4'b0000, 1'b0, 0, 1'b0);
        do_cycle("empty_wait", 4'b0100, 4'b0000, 1'b0, 0, 1'b0);
        n_cmp++;
        if (bus.pool_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL empty_flag: got %b want 1", bus.pool_empty);
        end
        do_cycle("empty_free5", 4'b0100, 4'b0000, 1'b1, 5, 1'b0);
        do_cycle("empty_grant", 4'b0100, 4'b0000, 1'b0, 0, 1'b0);
        n_cmp++;
        if (bus.alloc_id !== ID_W'(5) || bus.alloc_owner !== 2'd2) begin
            n_bad++;
            $display("FAIL empty_refill: got id %0d owner %0d want id 5 owner 2",
                     bus.alloc_id, bus.alloc_owner);
        end
        do_cycle("empty_idle", 4'b0000, 4'b0000, 1'b0, 0, 1'b0);
    endtask

    task automatic test_double_free();
        do_cycle("dfree_rst", 4'b0000, 4'b0000, 1'b0, 0, 1'b1);
        do_cycle("dfree7", 4'b0000, 4'b0000, 1'b1, 7, 1'b0);
        n_cmp++;
        if (bus.err_double_free !== 1'b1) begin
            n_bad++;
            $display("FAIL dfree_pulse: got %b want 1", bus.err_double_free);
        end
        do_cycle("dfree_after", 4'b0000, 4'b0000, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) do_cycle("dfree_alloc", 4'b0001, 4'b0000, 1'b0, 0, 1'b0);
        do_cycle("grant_and_free3", 4'b0001, 4'b0000, 1'b1, 3, 1'b0);
        n_cmp++;
        if (bus.alloc_id !== ID_W'(4) || bus.pool_count !== CNT_W'(N_OBJ - RES - 4)) begin
            n_bad++;
            $display("FAIL grant_free_same: got id %0d count %0d want id 4 count %0d",
                     bus.alloc_id, bus.pool_count, N_OBJ - RES - 4);
        end
        do_cycle("reuse3", 4'b0001, 4'b0000, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_cycle("mid_rst", 4'b0000, 4'b0000, 1'b0, 0, 1'b1);
        for (int i = 0; i < 10; i++) do_cycle("mid_alloc", 4'b1111, 4'b0000, 1'b0, 0, 1'b0);
        do_cycle("mid_reset", 4'b1111, 4'b0000, 1'b0, 0, 1'b1);
        n_cmp++;
        if (bus.alloc_valid !== 1'b0 || bus.pool_count !== CNT_W'(N_OBJ - RES)) begin
            n_bad++;
            $display("FAIL mid_reset_state: got valid %b count %0d want 0 %0d",
                     bus.alloc_valid, bus.pool_count, N_OBJ - RES);
        end
        do_cycle("mid_rr0", 4'b1111, 4'b0000, 1'b0, 0, 1'b0);
        do_cycle("mid_idle", 4'b0000, 4'b0000, 1'b0, 0, 1'b0);
    endtask

`ifdef OBJ_POOL_SINGLETON_EN
    task automatic test_singleton();
        do_cycle("sgl_rst", 4'b0000, 4'b0000, 1'b0, 0, 1'b1);
        for (int i = 0; i < N_OBJ - 1; i++) do_cycle("sgl_fill", 4'b0001, 4'b0000, 1'b0, 0, 1'b0);
        do_cycle("sgl_req", 4'b0010, 4'b0010, 1'b0, 0, 1'b0);
        n_cmp++;
        if (bus.alloc_id !== ID_W'(N_OBJ - 1) || bus.pool_count !== '0) begin
            n_bad++;
            $display("FAIL sgl_grant: got id %0d count %0d want %0d 0", bus.alloc_id,
                     bus.pool_count, N_OBJ - 1);
        end
        do_cycle("sgl_free", 4'b0000, 4'b0000, 1'b1, N_OBJ - 1, 1'b0);
        do_cycle("sgl_idle", 4'b0000, 4'b0000, 1'b0, 0, 1'b0);
    endtask
`endif

    task automatic test_random();
        logic [N_REQ-1:0] want;
        logic [N_REQ-1:0] sgl;
        logic             fv;
        logic             r;
        int               fid;
        int               start;
        bit               found;
        want = '0;
        sgl  = '0;
        do_cycle("rnd_rst", 4'b0000, 4'b0000, 1'b0, 0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!want[k]) begin
                    want[k] = ($urandom_range(3) == 0);
                    sgl[k]  = (RES == 1) && ($urandom_range(3) == 0);
                end
            end
            fv  = ($urandom_range(2) == 0);
            fid = $urandom_range(N_OBJ - 1);
            if ($urandom_range(4) != 0) begin
                start = $urandom_range(N_OBJ - 1);
                found = 0;
                for (int i = 0; i < N_OBJ; i++) begin
                    int j;
                    j = (start + i) % N_OBJ;
                    if (!found && !m_free[j] && !(RES == 1 && j == N_OBJ - 1)) begin
                        fid   = j;
                        found = 1;
                    end
                end
            end
            r = ($urandom_range(99) == 0);
            do_cycle("random", want, sgl, fv, fid, r);
            if (r) want = '0;
            else if (exp_av != 0 && $urandom_range(1) == 0) want[exp_owner] = 1'b0;
        end
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.free_valid = 1'b0;
        bus.free_id    = '0;
`ifdef OBJ_POOL_SINGLETON_EN
        bus.req_single = '0;
`endif
        model_reset();
        test_reset();
        test_single_requester();
        test_round_robin();
        test_empty_pool();
        test_double_free();
        test_reset_mid();
`ifdef OBJ_POOL_SINGLETON_EN
        test_singleton();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/obj_pool_arbiter.md
# obj_pool_arbiter

Hardware object-handle allocator that shares a fixed pool of N_OBJ object handles between N_REQ requesters, the RTL counterpart of the team's factory/singleton creation pattern. Requesters ask for a new object and receive a unique handle ID. Owners return handles through a single free port. The block arbitrates round-robin, tracks the free pool as a bitmap, and optionally serves a shared singleton handle.

## Interface
- N_REQ, 4, number of requesters (2..8)
- N_OBJ, 16, number of object handles (4..64, power of two)
- ID_W, $clog2(N_OBJ), handle ID width (derived, not overridden)
- CNT_W, $clog2(N_OBJ+1), pool count width (derived)

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester allocate request; held until granted
- req_ready  out  N_REQ  one-hot grant, combinational from registered state and req_valid
- alloc_valid  out  1  allocation response valid, one cycle after grant
- alloc_id  out  ID_W  allocated handle
- alloc_owner  out  $clog2(N_REQ)  index of granted requester
- free_valid  in  1  return a handle
- free_id  in  ID_W  handle being returned
- pool_count  out  CNT_W  free handles currently available
- pool_empty  out  1  pool_count == 0
- err_double_free  out  1  one-cycle pulse: freed handle was already free

## Operation
- Free bitmap free_map[N_OBJ]. Bit set means the handle is available. A grant always takes the lowest-index set bit.
- Arbitration:
  - Round-robin pointer rr_ptr holds the highest-priority requester.
  - Search order is rr_ptr, rr_ptr+1, … modulo N_REQ.
  - At most one grant per cycle, and only when pool_count > 0.
  - After a grant to requester k, rr_ptr becomes k+1 mod N_REQ.
  - rr_ptr does not change when nothing is granted.
- Handshake:
  - A grant occurs on the cycle req_valid[k] && req_ready[k].
  - The requester must deassert req_valid, or keep it high to request another handle, in the next cycle.
  - A requester must not drop req_valid before it is granted.
- On grant:
  - free_map bit clears and pool_count decrements.
  - Next cycle: alloc_valid=1, alloc_id=the handle, alloc_owner=k.
- Free:
  - free_valid with free_map[free_id]==0 sets the bit and increments pool_count on the next edge.
  - If the bit is already 1, the map is unchanged and err_double_free pulses next cycle.
- Simultaneous grant and free in one cycle:
  - Both are applied, so pool_count is unchanged.
  - The handle freed that cycle is not a grant candidate until the following cycle.
- Empty pool: all req_ready=0, requests wait, and no error is raised.
- Full pool: a free of any handle is a double free.

## Timing
- Reset values:
  - free_map all ones.
  - pool_count=N_OBJ (N_OBJ-1 with the singleton feature).
  - pool_empty=0, rr_ptr=0.
  - alloc_valid=0, alloc_id=0, alloc_owner=0, err_double_free=0.
  - req_ready=0 during the reset cycle.
- Latency:
  - Grant to alloc_valid: 1 cycle.
  - free_valid to handle reusable: grant possible on the cycle after the free edge.
- Throughput: one allocation per cycle while the pool is non-empty.
- Reset asserted mid-operation:
  - Outstanding handles are forgotten and the pool is full after the reset edge.
  - An alloc_valid due in the cycle after reset is suppressed.

## Configuration
- OBJ_POOL_SINGLETON_EN defined:
  - Adds input req_single (N_REQ). With req_valid[k], it marks a singleton request.
  - Handle N_OBJ-1 is reserved as the singleton: it is never in free_map, and pool_count starts at N_OBJ-1.
  - Singleton requests join the same round-robin.
  - A singleton request is grantable even when the pool is empty, and always returns alloc_id=N_OBJ-1 without changing pool_count.
  - free_id=N_OBJ-1 is silently ignored: no error, no count change.
- OBJ_POOL_SINGLETON_EN undefined:
  - req_single is absent.
  - All N_OBJ handles are allocatable.
  - Freeing N_OBJ-1 follows the normal rules.

## Test plan
- Reset, then req_valid=4'b0001 for 3 cycles -> alloc_id 0,1,2 on consecutive cycles, owner 0, pool_count 16→13.
- req_valid=4'b1111 held for 4 grants from reset -> grants in order 0,1,2,3 and ids 0..3. rr_ptr wraps to 0.
- Allocate all 16 handles, then hold req_valid[2] -> req_ready stays 0 and pool_empty=1. Free id 5 -> next cycle grant to 2, then alloc_id=5.
- Free id 7 while it is already free -> err_double_free pulses once, pool_count unchanged. A grant and a free of id 3 in the same cycle -> pool_count unchanged, and id 3 is not granted that cycle.
- Assert rst while 10 handles are outstanding and a grant is in flight -> no alloc_valid after reset, pool_count=16, rr_ptr=0.
- With OBJ_POOL_SINGLETON_EN, on an empty pool, req_single[1]&req_valid[1] -> alloc_id=15, pool_count stays 0. free_id=15 -> no error, no change.
